fft_banked_mem: RTL and testbench

- Parametrised banked complex-sample store for the FFT pipeline, holding real and imaginary planes.
- Organised as one long group plus NumShortGroups short groups. Each group holds NumLanes single-port banks per plane.
- Per cycle it accepts one lane-parallel write and one read. The read is either row mode (all lanes of one group) or column mode (one lane index across all groups, used for the inter-stage transpose).
- Adds what the previous generation lacked: valid/ready handshakes, write-over-read conflict arbitration, fixed pipelined read latency with a valid strobe, and address-range checking.

---
 rtl/fft_mem_pkg.sv | 28 ++
 rtl/fft_mem_bank.sv | 24 ++
 rtl/fft_banked_mem.sv | 135 +++++++++++++
 tb/tb_fft_banked_mem.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/fft_mem_pkg.sv
// Shared types and default sizes for the banked FFT sample store.
// Real and imaginary planes use the same types.
`ifndef SFP_WIDTH
`define SFP_WIDTH 16
`endif

package fft_mem_pkg;

  localparam int DefSfpWidth       = `SFP_WIDTH;
  localparam int DefNumLanes       = 4;
  localparam int DefNumShortGroups = 3;
  localparam int DefLongDepth      = 128;
  localparam int DefShortDepth     = 32;
  localparam int DefNumGroups      = 1 + DefNumShortGroups;

  typedef logic [DefSfpWidth-1:0] sfp_t;

  typedef enum logic {
    RdRow = 1'b0,
    RdCol = 1'b1
  } rd_mode_e;

  typedef logic [$clog2(DefLongDepth)-1:0]  long_addr_t;
  typedef logic [$clog2(DefShortDepth)-1:0] short_addr_t;
  typedef logic [$clog2(DefNumGroups)-1:0]  grp_idx_t;
  typedef logic [$clog2(DefNumLanes)-1:0]   lane_idx_t;

endpackage

// File: rtl/fft_mem_bank.sv
// Behavioural single-port bank.
// A write and a read must never be requested in the same cycle.
module fft_mem_bank
  import fft_mem_pkg::*;
#(
  parameter int Depth = DefShortDepth,
  parameter int Width = DefSfpWidth
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic                     re,
  input  logic [$clog2(Depth)-1:0] addr,
  input  logic [Width-1:0]         wdata,
  output logic [Width-1:0]         rdata
);

  logic [Width-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/fft_banked_mem.sv
// Banked complex-sample store: one long group plus short groups, row or column
// (transpose) reads with write priority, range checking and a 2-cycle read pipeline.
module fft_banked_mem
  import fft_mem_pkg::*;
#(
  parameter int SfpWidth       = DefSfpWidth,
  parameter int NumLanes       = DefNumLanes,
  parameter int NumShortGroups = DefNumShortGroups,
  parameter int LongDepth      = DefLongDepth,
  parameter int ShortDepth     = DefShortDepth
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                wr_valid_i,
  output logic                                wr_ready_o,
  input  logic [$clog2(1+NumShortGroups)-1:0] wr_grp_i,
  input  logic [$clog2(LongDepth)-1:0]        wr_addr_i,
  input  logic [NumLanes*SfpWidth-1:0]        wr_dr_i,
  input  logic [NumLanes*SfpWidth-1:0]        wr_di_i,
  input  logic                                rd_valid_i,
  output logic                                rd_ready_o,
  input  logic                                rd_mode_i,
  input  logic [$clog2(NumLanes)-1:0]         rd_sel_i,
  input  logic [$clog2(LongDepth)-1:0]        rd_addr_i,
  output logic                                rd_valid_o,
  output logic [NumLanes*SfpWidth-1:0]        rd_dr_o,
  output logic [NumLanes*SfpWidth-1:0]        rd_di_o,
  output logic                                err_addr_o
);

  localparam int NumGroups = 1 + NumShortGroups;
  localparam int GrpW      = $clog2(NumGroups);
  localparam int LaneW     = $clog2(NumLanes);
  localparam int AddrW     = $clog2(LongDepth);
  localparam int ShortW    = $clog2(ShortDepth);
  localparam int IdxW      = (GrpW > LaneW) ? GrpW : LaneW;

  if (NumGroups != NumLanes) begin : g_bad_shape
    $error("fft_banked_mem: column mode needs NumGroups == NumLanes");
  end

  logic wr_bad, rd_bad, conflict, wr_fire, rd_fire;
  logic [SfpWidth-1:0] bank_dr [NumGroups][NumLanes];
  logic [SfpWidth-1:0] bank_di [NumGroups][NumLanes];

  // Short groups only decode the low address bits, so anything above must be zero.
  assign wr_bad   = (wr_grp_i != '0) && (|wr_addr_i[AddrW-1:ShortW]);
  assign rd_bad   = ((rd_mode_i == RdCol) || (rd_sel_i != '0)) && (|rd_addr_i[AddrW-1:ShortW]);
  assign conflict = wr_valid_i &&
                    ((rd_mode_i == RdCol) || (IdxW'(wr_grp_i) == IdxW'(rd_sel_i)));

  assign wr_ready_o = !rst_i;
  assign rd_ready_o = !rst_i && !conflict;
  assign wr_fire    = wr_valid_i && wr_ready_o && !wr_bad;
  assign rd_fire    = rd_valid_i && rd_ready_o;

  for (genvar g = 0; g < NumGroups; g++) begin : g_grp
    localparam int Depth  = (g == 0) ? LongDepth : ShortDepth;
    localparam int BankAw = $clog2(Depth);
    logic              wr_here, rd_here;
    logic [BankAw-1:0] addr;

    assign wr_here = wr_fire && (wr_grp_i == GrpW'(g));
    assign rd_here = rd_fire && ((rd_mode_i == RdCol) || (rd_sel_i == LaneW'(g)));
    assign addr    = wr_here ? wr_addr_i[BankAw-1:0] : rd_addr_i[BankAw-1:0];

    for (genvar l = 0; l < NumLanes; l++) begin : g_lane
      fft_mem_bank #(.Depth(Depth), .Width(SfpWidth)) u_bank_r (
        .clk   (clk_i),
        .we    (wr_here),
        .re    (rd_here),
        .addr  (addr),
        .wdata (wr_dr_i[l*SfpWidth +: SfpWidth]),
        .rdata (bank_dr[g][l])
      );
      fft_mem_bank #(.Depth(Depth), .Width(SfpWidth)) u_bank_i (
        .clk   (clk_i),
        .we    (wr_here),
        .re    (rd_here),
        .addr  (addr),
        .wdata (wr_di_i[l*SfpWidth +: SfpWidth]),
        .rdata (bank_di[g][l])
      );
    end
  end

  logic                          s1_valid, s1_bad;
  rd_mode_e                      s1_mode;
  logic [LaneW-1:0]              s1_sel;
  logic [NumLanes*SfpWidth-1:0]  steer_dr, steer_di;

  // Column mode reverses group order so the long group lands on the top lane.
  always_comb begin
    steer_dr = '0;
    steer_di = '0;
    if (s1_mode == RdRow) begin
      for (int k = 0; k < NumLanes; k++) begin
        steer_dr[k*SfpWidth +: SfpWidth] = bank_dr[GrpW'(s1_sel)][k];
        steer_di[k*SfpWidth +: SfpWidth] = bank_di[GrpW'(s1_sel)][k];
      end
    end else begin
      for (int g = 0; g < NumGroups; g++) begin
        steer_dr[(NumLanes-1-g)*SfpWidth +: SfpWidth] = bank_dr[g][s1_sel];
        steer_di[(NumLanes-1-g)*SfpWidth +: SfpWidth] = bank_di[g][s1_sel];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid   <= 1'b0;
      s1_bad     <= 1'b0;
      s1_mode    <= RdRow;
      s1_sel     <= '0;
      rd_valid_o <= 1'b0;
      rd_dr_o    <= '0;
      rd_di_o    <= '0;
      err_addr_o <= 1'b0;
    end else begin
      s1_valid <= rd_fire;
      if (rd_fire) begin
        s1_mode <= rd_mode_e'(rd_mode_i);
        s1_sel  <= rd_sel_i;
        s1_bad  <= rd_bad;
      end
      rd_valid_o <= s1_valid;
      if (s1_valid) begin
        rd_dr_o <= s1_bad ? '0 : steer_dr;
        rd_di_o <= s1_bad ? '0 : steer_di;
      end
      if ((wr_valid_i && wr_bad) || (rd_fire && rd_bad)) err_addr_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fft_banked_mem.sv
// Directed self-checking bench for fft_banked_mem: row/column reads, conflicts,
// range errors, throughput and mid-stream reset, all with hand-computed values.
module tb_fft_banked_mem;

  localparam int W = 16;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        wr_valid_i;
  logic        wr_ready_o;
  logic [1:0]  wr_grp_i;
  logic [6:0]  wr_addr_i;
  logic [63:0] wr_dr_i, wr_di_i;
  logic        rd_valid_i;
  logic        rd_ready_o;
  logic        rd_mode_i;
  logic [1:0]  rd_sel_i;
  logic [6:0]  rd_addr_i;
  logic        rd_valid_o;
  logic [63:0] rd_dr_o, rd_di_o;
  logic        err_addr_o;

  int compared = 0;
  int mismatched = 0;

  fft_banked_mem #(
    .SfpWidth(W), .NumLanes(4), .NumShortGroups(3), .LongDepth(128), .ShortDepth(32)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_grp_i(wr_grp_i),
    .wr_addr_i(wr_addr_i), .wr_dr_i(wr_dr_i), .wr_di_i(wr_di_i),
    .rd_valid_i(rd_valid_i), .rd_ready_o(rd_ready_o), .rd_mode_i(rd_mode_i),
    .rd_sel_i(rd_sel_i), .rd_addr_i(rd_addr_i),
    .rd_valid_o(rd_valid_o), .rd_dr_o(rd_dr_o), .rd_di_o(rd_di_o),
    .err_addr_o(err_addr_o)
  );

  always #5 clk = ~clk;

  // Lane 0 is the least significant sample.
  function automatic logic [63:0] pack(input int l0, input int l1, input int l2, input int l3);
    return {16'(l3), 16'(l2), 16'(l1), 16'(l0)};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic wv, input logic [1:0] wg, input logic [6:0] wa,
                               input logic [63:0] dr, input logic [63:0] di,
                               input logic rv, input logic rm, input logic [1:0] rs,
                               input logic [6:0] ra);
    wr_valid_i = wv; wr_grp_i = wg; wr_addr_i = wa; wr_dr_i = dr; wr_di_i = di;
    rd_valid_i = rv; rd_mode_i = rm; rd_sel_i = rs; rd_addr_i = ra;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 2'd0, 7'd0, 64'd0, 64'd0, 1'b0, 1'b0, 2'd0, 7'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic writeWord(input logic [1:0] g, input logic [6:0] a,
                           input logic [63:0] dr, input logic [63:0] di);
    applyStimulus(1'b1, g, a, dr, di, 1'b0, 1'b0, 2'd0, 7'd0);
    tick();
  endtask

  task automatic readWord(input logic rm, input logic [1:0] s, input logic [6:0] a);
    applyStimulus(1'b0, 2'd0, 7'd0, 64'd0, 64'd0, 1'b1, rm, s, a);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_i = 1'b1;
    idle();
    tick(); tick();
    checkOutput("rst_wr_ready", 64'(wr_ready_o), 64'd0);
    checkOutput("rst_rd_ready", 64'(rd_ready_o), 64'd0);
    checkOutput("rst_rd_valid", 64'(rd_valid_o), 64'd0);
    checkOutput("rst_rd_dr", rd_dr_o, 64'd0);
    checkOutput("rst_rd_di", rd_di_o, 64'd0);
    checkOutput("rst_err", 64'(err_addr_o), 64'd0);
    rst_i = 1'b0;
    #1;
    checkOutput("wr_ready_up", 64'(wr_ready_o), 64'd1);
    tick();

    // Row write then row read with latency 2
    writeWord(2'd2, 7'd5, pack(1, 2, 3, 4), pack(5, 6, 7, 8));
    readWord(1'b0, 2'd2, 7'd5);
    tick(); idle();
    checkOutput("row_lat1_valid", 64'(rd_valid_o), 64'd0);
    tick();
    checkOutput("row_valid", 64'(rd_valid_o), 64'd1);
    checkOutput("row_dr", rd_dr_o, pack(1, 2, 3, 4));
    checkOutput("row_di", rd_di_o, pack(5, 6, 7, 8));
    tick();
    checkOutput("row_valid_1cyc", 64'(rd_valid_o), 64'd0);

    // Column transpose: groups 0..3, addr 3, lanes 10g+k / 100+10g+k
    writeWord(2'd0, 7'd3, pack(0, 1, 2, 3),     pack(100, 101, 102, 103));
    writeWord(2'd1, 7'd3, pack(10, 11, 12, 13), pack(110, 111, 112, 113));
    writeWord(2'd2, 7'd3, pack(20, 21, 22, 23), pack(120, 121, 122, 123));
    writeWord(2'd3, 7'd3, pack(30, 31, 32, 33), pack(130, 131, 132, 133));
    readWord(1'b1, 2'd1, 7'd3);
    tick();
    readWord(1'b1, 2'd3, 7'd3);
    tick();
    checkOutput("col1_valid", 64'(rd_valid_o), 64'd1);
    checkOutput("col1_dr", rd_dr_o, pack(31, 21, 11, 1));
    checkOutput("col1_di", rd_di_o, pack(131, 121, 111, 101));
    idle();
    tick();
    checkOutput("col3_valid", 64'(rd_valid_o), 64'd1);
    checkOutput("col3_dr", rd_dr_o, pack(33, 23, 13, 3));
    checkOutput("col3_di", rd_di_o, pack(133, 123, 113, 103));
    tick();

    // Conflict: write grp 1 and row read grp 1 in the same cycle
    applyStimulus(1'b1, 2'd1, 7'd7, pack(40, 41, 42, 43), pack(50, 51, 52, 53),
                  1'b1, 1'b0, 2'd1, 7'd7);
    #1;
    checkOutput("conf_rd_ready", 64'(rd_ready_o), 64'd0);
    checkOutput("conf_wr_ready", 64'(wr_ready_o), 64'd1);
    tick();
    readWord(1'b0, 2'd1, 7'd7);
    #1;
    checkOutput("retry_rd_ready", 64'(rd_ready_o), 64'd1);
    tick(); idle();
    tick();
    checkOutput("retry_valid", 64'(rd_valid_o), 64'd1);
    checkOutput("retry_dr", rd_dr_o, pack(40, 41, 42, 43));
    checkOutput("retry_di", rd_di_o, pack(50, 51, 52, 53));
    tick();
    checkOutput("conf_no_extra", 64'(rd_valid_o), 64'd0);

    // Column read conflicts with any write
    applyStimulus(1'b1, 2'd0, 7'd9, pack(0, 0, 0, 0), pack(0, 0, 0, 0),
                  1'b1, 1'b1, 2'd2, 7'd3);
    #1;
    checkOutput("col_conf_ready", 64'(rd_ready_o), 64'd0);
    tick();

    // Non-conflicting write grp 1 + row read grp 3 in the same cycle
    applyStimulus(1'b1, 2'd1, 7'd8, pack(60, 61, 62, 63), pack(64, 65, 66, 67),
                  1'b1, 1'b0, 2'd3, 7'd3);
    #1;
    checkOutput("noconf_rd_ready", 64'(rd_ready_o), 64'd1);
    tick();
    readWord(1'b0, 2'd1, 7'd8);
    tick();
    checkOutput("noconf_valid", 64'(rd_valid_o), 64'd1);
    checkOutput("noconf_g3_dr", rd_dr_o, pack(30, 31, 32, 33));
    idle();
    tick();
    checkOutput("noconf_g1_dr", rd_dr_o, pack(60, 61, 62, 63));
    checkOutput("noconf_g1_di", rd_di_o, pack(64, 65, 66, 67));

    // Range: top of long group is legal
    writeWord(2'd0, 7'd127, pack(16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD), pack(1, 2, 3, 4));
    readWord(1'b0, 2'd0, 7'd127);
    tick(); idle(); tick();
    checkOutput("long127_valid", 64'(rd_valid_o), 64'd1);
    checkOutput("long127_dr", rd_dr_o, pack(16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD));
    checkOutput("long127_err", 64'(err_addr_o), 64'd0);

    // Range: grp 2 addr 40 aliases addr 8 and must be dropped
    writeWord(2'd2, 7'd8, pack(70, 71, 72, 73), pack(80, 81, 82, 83));
    checkOutput("pre_bad_err", 64'(err_addr_o), 64'd0);
    writeWord(2'd2, 7'd40, pack(99, 99, 99, 99), pack(99, 99, 99, 99));
    checkOutput("bad_wr_err", 64'(err_addr_o), 64'd1);
    readWord(1'b0, 2'd2, 7'd8);
    tick(); idle(); tick();
    checkOutput("bad_wr_dropped_dr", rd_dr_o, pack(70, 71, 72, 73));
    checkOutput("bad_wr_dropped_di", rd_di_o, pack(80, 81, 82, 83));

    // Out-of-range read completes with zero data
    readWord(1'b0, 2'd1, 7'd33);
    tick(); idle(); tick();
    checkOutput("bad_rd_valid", 64'(rd_valid_o), 64'd1);
    checkOutput("bad_rd_dr", rd_dr_o, 64'd0);
    checkOutput("bad_rd_di", rd_di_o, 64'd0);
    tick(); tick();
    checkOutput("err_sticky", 64'(err_addr_o), 64'd1);

    // Throughput: 8 back-to-back row reads of grp 3
    for (int i = 0; i < 8; i++)
      writeWord(2'd3, 7'(i), pack(200+4*i, 201+4*i, 202+4*i, 203+4*i),
                pack(1200+4*i, 1201+4*i, 1202+4*i, 1203+4*i));
    for (int i = 0; i < 10; i++) begin
      if (i < 8) readWord(1'b0, 2'd3, 7'(i));
      else idle();
      tick();
      checkOutput($sformatf("tput_valid_%0d", i), 64'(rd_valid_o),
                  64'((i >= 1 && i <= 8) ? 1 : 0));
      if (i >= 1 && i <= 8) begin
        checkOutput($sformatf("tput_dr_%0d", i-1), rd_dr_o,
                    pack(200+4*(i-1), 201+4*(i-1), 202+4*(i-1), 203+4*(i-1)));
        checkOutput($sformatf("tput_di_%0d", i-1), rd_di_o,
                    pack(1200+4*(i-1), 1201+4*(i-1), 1202+4*(i-1), 1203+4*(i-1)));
      end
    end

    // Reset mid-stream kills in-flight reads and clears the error flag
    readWord(1'b0, 2'd3, 7'd0); tick();
    readWord(1'b0, 2'd3, 7'd1); tick();
    readWord(1'b0, 2'd3, 7'd2); tick();
    idle();
    rst_i = 1'b1;
    #1;
    checkOutput("mid_rst_wr_ready", 64'(wr_ready_o), 64'd0);
    checkOutput("mid_rst_rd_ready", 64'(rd_ready_o), 64'd0);
    tick();
    checkOutput("mid_rst_valid", 64'(rd_valid_o), 64'd0);
    checkOutput("mid_rst_err", 64'(err_addr_o), 64'd0);
    rst_i = 1'b0;
    tick();
    checkOutput("post_rst_valid_a", 64'(rd_valid_o), 64'd0);
    tick();
    checkOutput("post_rst_valid_b", 64'(rd_valid_o), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
